// File: rtl/ysyx_25040109_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, reset values,
// identification values, trap causes and mstatus bit positions.
package ysyx_25040109_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL   = 32'h017E_14ED;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] MTVEC_RST   = 32'h0000_0000;
    localparam logic [31:0] MEPC_RST    = 32'h0000_0000;
    localparam logic [31:0] MCAUSE_RST  = 32'h0000_0000;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // Per-cycle action, already prioritised: ecall beats mret beats a write.
    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_WRITE = 2'd1,
        ACT_ECALL = 2'd2,
        ACT_MRET  = 2'd3
    } csr_act_e;

    // MPP is hardwired to machine mode; only MIE/MPIE hold state.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] r;
        r = '0;
        r[MSTATUS_MPP_LO +: 2] = 2'b11;
        r[MSTATUS_MPIE] = mpie;
        r[MSTATUS_MIE] = mie;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25040109_csr_counter.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to one half wins over that cycle's increment and leaves the other half alone.
module ysyx_25040109_csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (we_lo) begin
            lo_q <= wdata;
        end else if (we_hi) begin
            hi_q <= wdata;
        end else if (inc) begin
            {hi_q, lo_q} <= {hi_q, lo_q} + 64'd1;
        end
    end

    assign count = {hi_q, lo_q};

endmodule

// File: rtl/ysyx_25040109_csr.sv
// Machine-mode CSR file with combinational read, commit-gated writes and ecall/mret.
// Define YSYX_25040109_CSR_COUNTERS_EN to add the mcycle/minstret counters.
module ysyx_25040109_csr
    import ysyx_25040109_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] pc,
    output logic [31:0] csr_rdata,
    output logic [31:0] mepc,
    output logic [31:0] mtvec,
    output logic        csr_illegal
);

    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic        mapped;
    logic        read_only;
    logic        csr_wr;
    csr_act_e    act;

`ifdef YSYX_25040109_CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    ysyx_25040109_csr_counter u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .we_lo (csr_wr && (csr_addr == CSR_MCYCLE)),
        .we_hi (csr_wr && (csr_addr == CSR_MCYCLEH)),
        .wdata (csr_wdata),
        .count (mcycle)
    );

    ysyx_25040109_csr_counter u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit),
        .we_lo (csr_wr && (csr_addr == CSR_MINSTRET)),
        .we_hi (csr_wr && (csr_addr == CSR_MINSTRETH)),
        .wdata (csr_wdata),
        .count (minstret)
    );
`endif

    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b0;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_pack(mie_q, mpie_q);
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MVENDORID: begin
                csr_rdata = MVENDORID_VAL;
                read_only = 1'b1;
            end
            CSR_MARCHID: begin
                csr_rdata = MARCHID_VAL;
                read_only = 1'b1;
            end
`ifdef YSYX_25040109_CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
            default:       mapped = 1'b0;
        endcase
    end

    assign csr_illegal = !mapped || (csr_we && read_only);

    always_comb begin
        act = ACT_NONE;
        if (commit) begin
            if (is_ecall)                             act = ACT_ECALL;
            else if (is_mret)                         act = ACT_MRET;
            else if (csr_we && mapped && !read_only)  act = ACT_WRITE;
        end
    end

    assign csr_wr = (act == ACT_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q    <= MSTATUS_RST[MSTATUS_MIE];
            mpie_q   <= MSTATUS_RST[MSTATUS_MPIE];
            mtvec_q  <= MTVEC_RST;
            mepc_q   <= MEPC_RST;
            mcause_q <= MCAUSE_RST;
        end else begin
            case (act)
                ACT_ECALL: begin
                    mepc_q   <= pc & ~32'h3;
                    mcause_q <= MCAUSE_ECALL_M;
                    mpie_q   <= mie_q;
                    mie_q    <= 1'b0;
                end
                ACT_MRET: begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end
                ACT_WRITE: begin
                    case (csr_addr)
                        CSR_MSTATUS: begin
                            mie_q  <= csr_wdata[MSTATUS_MIE];
                            mpie_q <= csr_wdata[MSTATUS_MPIE];
                        end
                        CSR_MTVEC:  mtvec_q  <= csr_wdata & ~32'h3;
                        CSR_MEPC:   mepc_q   <= csr_wdata & ~32'h3;
                        CSR_MCAUSE: mcause_q <= csr_wdata;
                        default:    ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mepc  = mepc_q;
    assign mtvec = mtvec_q;

endmodule

// File: doc/ysyx_25040109_csr.md
YSYX_25040109_CSR -- requirements
Module: ysyx_25040109_CSR

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port commit, input, 1 bit: the current instruction retires this cycle; every state update except the cycle counter is gated by it.
REQ-004 SHALL have port csr_addr, input, 12 bits: CSR index for the read port and the write port.
REQ-005 SHALL have port csr_we, input, 1 bit: write request from the execute stage.
REQ-006 SHALL have port csr_wdata, input, 32 bits: write value, already merged for CSRRW or CSRRS.
REQ-007 SHALL have ports is_ecall and is_mret, input, 1 bit each: trap entry and trap return.
REQ-008 SHALL have port pc, input, 32 bits: PC of the retiring instruction.
REQ-009 SHALL have port csr_rdata, output, 32 bits: combinational read data.
REQ-010 SHALL have ports mepc and mtvec, output, 32 bits each: registered copies for next-PC selection.
REQ-011 SHALL have port csr_illegal, output, 1 bit: combinational; asserts for an unmapped address, or for csr_we to a read-only address.

Function
REQ-012 SHALL implement the CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mvendorid 0xF11 (read-only, 0x79737978), marchid 0xF12 (read-only, 0x017E14ED).
REQ-013 SHALL make the read path fully combinational: csr_rdata follows csr_addr in the same cycle, and an unmapped address reads 0.
REQ-014 SHALL return the pre-write value on a read in the same cycle as a write to that address; the new value is visible the next cycle.
REQ-015 SHALL apply a write when commit=1, csr_we=1, the address is mapped and writable, and neither is_ecall nor is_mret is asserted.
REQ-016 SHALL treat mstatus as follows: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads as 2'b11; all other bits read 0.
REQ-017 SHALL hardwire mtvec[1:0] and mepc[1:0] to 0; mtvec is direct mode only.
REQ-018 SHALL perform trap entry on commit=1 with is_ecall=1, all at the next edge:
- mepc <= pc & ~3
- mcause <= 32'd11
- MPIE <= MIE
- MIE <= 0
REQ-019 SHALL perform trap return on commit=1 with is_mret=1: MIE <= MPIE, MPIE <= 1; mepc is unchanged.
REQ-020 SHALL give is_ecall priority over is_mret when both are asserted, so that only the trap entry occurs.
REQ-021 SHALL make no state change when commit=0, except counters (REQ-025).

Reset
REQ-022 SHALL, while rst_n=0, immediately force:
- mstatus = 0x00001800
- mtvec = 0
- mepc = 0
- mcause = 0
- counters = 0
REQ-023 SHALL discard any trap or write in progress when reset is asserted mid-operation, and drive outputs to reset-derived values within the same cycle.
REQ-024 SHALL begin the first update at the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with YSYX_25040109_CSR_COUNTERS_EN defined, add 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02 low, 0xB82 high):
- mcycle increments every cycle.
- minstret increments on each commit.
- Both wrap from all-ones to 0.
- A CSR write to either half takes precedence over that cycle's increment; the other half holds.
REQ-026 SHALL, without YSYX_25040109_CSR_COUNTERS_EN, leave addresses 0xB00/0xB80/0xB02/0xB82 unmapped (reads return 0, csr_illegal=1), with no counter flops.

Structure
REQ-027 SHALL place the following in package ysyx_25040109_csr_pkg: CSR address constants, reset values, the mvendorid/marchid constants, mcause codes, and mstatus bit positions.
REQ-028 SHALL implement each 64-bit counter as an instance of sub-module ysyx_25040109_csr_counter, with inc, 32-bit write-low/write-high ports, and async active-low reset.

Verification
REQ-029 SHALL cover: write mtvec=0x80000103 -> mtvec reads 0x80000100 next cycle; same-cycle read returns the old value.
REQ-030 SHALL cover: MIE=1, ecall at pc=0x80000044 -> next cycle mepc=0x80000044, mcause=11, mstatus=0x00001880.
REQ-031 SHALL cover: mret after REQ-030 -> mstatus=0x00001888, mepc still 0x80000044.
REQ-032 SHALL cover: csr_we to 0xF11 -> csr_illegal=1, value still 0x79737978; read of 0x7C0 -> 0, csr_illegal=1.
REQ-033 SHALL cover, with counters enabled: write mcycle low=0xFFFFFFFF, high=0 -> two cycles later high=1, low=0x00000001.
REQ-034 SHALL cover: assert rst_n=0 mid-ecall (commit=1) -> mepc=0, mstatus=0x00001800 before the next edge.
